// File: rtl/player_ctrl.sv
// player_ctrl: debounced push-button control of song index, pause and volume
// attenuation for an audio player, plus auto-advance on end-of-song.
module player_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_CYCLES   = 100000,
    parameter int unsigned NUM_SONGS       = 4,
    parameter logic [7:0]  VOL_STEP        = 8'h08,
    parameter logic [7:0]  VOL_INIT        = 8'h20
) (
    input  logic        clk_temp,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        btn_vol_up,
    input  logic        btn_vol_down,
    input  logic        btn_pause,
    input  logic        i_finish_song,
    output logic [2:0]  o_song_select,
    output logic        o_pause,
    output logic [15:0] o_vol
);

    localparam int unsigned NUM_IN    = 6;
    localparam int unsigned NUM_BTN   = 5;
    localparam int unsigned CNT_MAX   = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    // The cycle that first sees the new level already counts as stable,
    // so the counter terminates two below the debounce length.
    localparam int unsigned DB_LAST   = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam int unsigned RPT_LAST  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam int unsigned SONG_LAST = NUM_SONGS - 1;
    localparam logic [7:0]  ATT_MAX   = 8'hFE;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        HELD         = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_t;

    logic [NUM_IN-1:0]  raw;
    logic [NUM_IN-1:0]  meta;
    logic [NUM_IN-1:0]  sync;
    logic [NUM_BTN-1:0] pulse;
    logic               fin_prev;
    logic               fin_pulse;

    // Bit order: 0 next, 1 prev, 2 vol_up, 3 vol_down, 4 pause, 5 finish.
    assign raw = {i_finish_song, btn_pause, btn_vol_down, btn_vol_up, btn_prev, btn_next};

    // Two-flop synchronizer for every asynchronous input.
    always_ff @(posedge clk_temp or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Per-button debounce FSM; the volume buttons also auto-repeat while held.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        localparam bit RPT = (g == 2) || (g == 3);
        db_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             press;

        // Debounce state, stability/repeat counter and registered press pulse.
        always_ff @(posedge clk_temp or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
                press <= 1'b0;
            end else begin
                press <= 1'b0;
                case (state)
                    IDLE: begin
                        if (sync[g]) begin
                            state <= WAIT_PRESS;
                            cnt   <= '0;
                        end
                    end
                    WAIT_PRESS: begin
                        if (!sync[g]) begin
                            state <= IDLE;
                        end else if (cnt == CNT_W'(DB_LAST)) begin
                            state <= HELD;
                            cnt   <= '0;
                            press <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!sync[g]) begin
                            state <= WAIT_RELEASE;
                            cnt   <= '0;
                        end else if (RPT) begin
                            if (cnt == CNT_W'(RPT_LAST)) begin
                                cnt   <= '0;
                                press <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    WAIT_RELEASE: begin
                        if (sync[g]) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_W'(DB_LAST)) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign pulse[g] = press;
    end

    // Rising-edge detect on the synchronized end-of-song level.
    always_ff @(posedge clk_temp or negedge rst_n) begin
        if (!rst_n) fin_prev <= 1'b0;
        else        fin_prev <= sync[5];
    end
    assign fin_pulse = sync[5] & ~fin_prev;

    logic       adv;
    logic       ret;
    logic [2:0] song_inc;
    logic [2:0] song_dec;
    logic [7:0] att;
    logic [8:0] att_sum;
    logic [8:0] att_dif;
    logic [7:0] att_next;

    assign att = o_vol[7:0];

    // Next song / attenuation from this cycle's pulses.
    always_comb begin
        adv      = fin_pulse | (pulse[0] & ~pulse[1]);
        ret      = pulse[1] & ~pulse[0] & ~fin_pulse;
        song_inc = (o_song_select == 3'(SONG_LAST)) ? 3'd0 : o_song_select + 3'd1;
        song_dec = (o_song_select == 3'd0) ? 3'(SONG_LAST) : o_song_select - 3'd1;
        att_sum  = {1'b0, att} + {1'b0, VOL_STEP};
        att_dif  = {1'b0, att} - {1'b0, VOL_STEP};
        att_next = att;
        if (pulse[2] && !pulse[3]) begin
            att_next = att_dif[8] ? 8'h00 : att_dif[7:0];
        end else if (pulse[3] && !pulse[2]) begin
            att_next = (att_sum > {1'b0, ATT_MAX}) ? ATT_MAX : att_sum[7:0];
        end
    end

    // Registered outputs; a song change always clears pause.
    always_ff @(posedge clk_temp or negedge rst_n) begin
        if (!rst_n) begin
            o_song_select <= 3'd0;
            o_pause       <= 1'b0;
            o_vol         <= {VOL_INIT, VOL_INIT};
        end else begin
            if (adv) begin
                o_song_select <= song_inc;
                o_pause       <= 1'b0;
            end else if (ret) begin
                o_song_select <= song_dec;
                o_pause       <= 1'b0;
            end else if (pulse[4]) begin
                o_pause <= ~o_pause;
            end
            if (att_next != att) begin
                o_vol <= {att_next, att_next};
            end
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus randomized button traffic
// checked against a press-level behavioural model.
module tb_player_ctrl;

    localparam int DB       = 4;
    localparam int RPT      = 10;
    localparam int NSONG    = 4;
    localparam int STEP     = 8;

    logic        clk_temp;
    logic        rst_n;
    logic        btn_next;
    logic        btn_prev;
    logic        btn_vol_up;
    logic        btn_vol_down;
    logic        btn_pause;
    logic        i_finish_song;
    logic [2:0]  o_song_select;
    logic        o_pause;
    logic [15:0] o_vol;

    int passed = 0;
    int total  = 0;

    int m_song;
    int m_pause;
    int m_att;

    player_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RPT),
        .NUM_SONGS      (NSONG),
        .VOL_STEP       (8'h08),
        .VOL_INIT       (8'h20)
    ) dut (
        .clk_temp     (clk_temp),
        .rst_n        (rst_n),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .btn_vol_up   (btn_vol_up),
        .btn_vol_down (btn_vol_down),
        .btn_pause    (btn_pause),
        .i_finish_song(i_finish_song),
        .o_song_select(o_song_select),
        .o_pause      (o_pause),
        .o_vol        (o_vol)
    );

    initial clk_temp = 1'b0;
    always #5 clk_temp = ~clk_temp;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_temp);
        #1;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0:       btn_next     = v;
            1:       btn_prev     = v;
            2:       btn_vol_up   = v;
            3:       btn_vol_down = v;
            default: btn_pause    = v;
        endcase
    endtask

    task automatic press(input int idx, input int len);
        set_btn(idx, 1'b1);
        tick(len);
        set_btn(idx, 1'b0);
        tick(12);
    endtask

    task automatic model_reset();
        m_song  = 0;
        m_pause = 0;
        m_att   = 32;
    endtask

    task automatic model_press(input int idx);
        case (idx)
            0: begin m_song = (m_song + 1) % NSONG; m_pause = 0; end
            1: begin m_song = (m_song + NSONG - 1) % NSONG; m_pause = 0; end
            2: m_att = (m_att >= STEP) ? m_att - STEP : 0;
            3: m_att = (m_att + STEP > 254) ? 254 : m_att + STEP;
            4: m_pause = 1 - m_pause;
            default: begin m_song = (m_song + 1) % NSONG; m_pause = 0; end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_next = 0; btn_prev = 0; btn_vol_up = 0; btn_vol_down = 0;
        btn_pause = 0; i_finish_song = 0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_next = 0; btn_prev = 0; btn_vol_up = 0; btn_vol_down = 0;
        btn_pause = 0; i_finish_song = 0;
        tick(3);
        total++;
        if (o_song_select !== 3'd0) $display("FAIL reset_song: got %0d want 0", o_song_select);
        else passed++;
        total++;
        if (o_pause !== 1'b0) $display("FAIL reset_pause: got %0b want 0", o_pause);
        else passed++;
        total++;
        if (o_vol !== 16'h2020) $display("FAIL reset_vol: got %h want 2020", o_vol);
        else passed++;
        rst_n = 1'b1;
        tick(1);
        model_reset();
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            btn_next = 1'b1;
            tick(3);
            btn_next = 1'b0;
            tick(5);
        end
        tick(10);
        total++;
        if (o_song_select !== 3'd0) $display("FAIL bounce_glitch: got %0d want 0", o_song_select);
        else passed++;
        btn_next = 1'b1;
        tick(6);
        total++;
        if (o_song_select !== 3'd0) $display("FAIL bounce_early: got %0d want 0 at 6 cycles", o_song_select);
        else passed++;
        tick(1);
        total++;
        if (o_song_select !== 3'd1) $display("FAIL bounce_latency: got %0d want 1 at 7 cycles", o_song_select);
        else passed++;
        tick(3);
        btn_next = 1'b0;
        tick(12);
        total++;
        if (o_song_select !== 3'd1) $display("FAIL bounce_single: got %0d want 1", o_song_select);
        else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        press(1, 8);
        total++;
        if (o_song_select !== 3'd3) $display("FAIL wrap_prev: got %0d want 3", o_song_select);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            press(0, 8);
            total++;
            if (o_song_select !== 3'(i)) $display("FAIL wrap_next%0d: got %0d want %0d", i, o_song_select, i);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] seen[$];
        logic [15:0] want[$];
        logic [15:0] last;
        int          a;
        int          bad;
        do_reset();
        last = o_vol;
        btn_vol_up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (o_vol !== last) begin
                seen.push_back(o_vol);
                last = o_vol;
            end
        end
        btn_vol_up = 1'b0;
        tick(12);
        want = '{16'h1818, 16'h1010, 16'h0808, 16'h0000};
        bad = 0;
        if (seen.size() != want.size()) bad = 1;
        else for (int i = 0; i < want.size(); i++) if (seen[i] !== want[i]) bad = 1;
        total++;
        if (bad != 0) $display("FAIL sat_up_seq: got %0d changes want %0d (1818,1010,0808,0000)", seen.size(), want.size());
        else passed++;
        total++;
        if (o_vol !== 16'h0000) $display("FAIL sat_up_final: got %h want 0000", o_vol);
        else passed++;

        seen.delete();
        want.delete();
        a = 0;
        while (a != 254) begin
            a = (a + STEP > 254) ? 254 : a + STEP;
            want.push_back({8'(a), 8'(a)});
        end
        btn_vol_down = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (o_vol !== last) begin
                seen.push_back(o_vol);
                last = o_vol;
            end
        end
        btn_vol_down = 1'b0;
        tick(12);
        bad = 0;
        if (seen.size() != want.size()) bad = 1;
        else for (int i = 0; i < want.size(); i++) if (seen[i] !== want[i]) bad = 1;
        total++;
        if (bad != 0) $display("FAIL sat_down_seq: got %0d changes want %0d ending F8F8,FEFE", seen.size(), want.size());
        else passed++;
        total++;
        if (o_vol !== 16'hFEFE) $display("FAIL sat_down_final: got %h want FEFE", o_vol);
        else passed++;
    endtask

    task automatic test_auto_advance();
        do_reset();
        press(0, 8);
        press(0, 8);
        press(4, 8);
        total++;
        if (o_song_select !== 3'd2 || o_pause !== 1'b1)
            $display("FAIL adv_setup: got song %0d pause %0b want 2/1", o_song_select, o_pause);
        else passed++;
        i_finish_song = 1'b1;
        tick(2);
        total++;
        if (o_song_select !== 3'd2) $display("FAIL adv_early: got %0d want 2", o_song_select);
        else passed++;
        tick(1);
        total++;
        if (o_song_select !== 3'd3 || o_pause !== 1'b0)
            $display("FAIL adv_step: got song %0d pause %0b want 3/0", o_song_select, o_pause);
        else passed++;
        tick(30);
        total++;
        if (o_song_select !== 3'd3) $display("FAIL adv_level_held: got %0d want 3", o_song_select);
        else passed++;
        i_finish_song = 1'b0;
        tick(5);
    endtask

    task automatic test_simultaneous();
        do_reset();
        // Finish raised 4 cycles after pause so both pulses land on the same edge.
        btn_pause = 1'b1;
        tick(4);
        i_finish_song = 1'b1;
        tick(4);
        btn_pause = 1'b0;
        i_finish_song = 1'b0;
        tick(12);
        total++;
        if (o_song_select !== 3'd1 || o_pause !== 1'b0)
            $display("FAIL sim_pause_finish: got song %0d pause %0b want 1/0", o_song_select, o_pause);
        else passed++;
        press(4, 8);
        total++;
        if (o_pause !== 1'b1) $display("FAIL sim_pause_toggle: got %0b want 1", o_pause);
        else passed++;
        btn_next = 1'b1;
        btn_prev = 1'b1;
        tick(8);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(12);
        total++;
        if (o_song_select !== 3'd1 || o_pause !== 1'b1)
            $display("FAIL sim_next_prev: got song %0d pause %0b want 1/1", o_song_select, o_pause);
        else passed++;
        btn_vol_up = 1'b1;
        btn_vol_down = 1'b1;
        tick(8);
        btn_vol_up = 1'b0;
        btn_vol_down = 1'b0;
        tick(12);
        total++;
        if (o_vol !== 16'h2020) $display("FAIL sim_up_down: got %h want 2020", o_vol);
        else passed++;
    endtask

    task automatic test_reset_hold();
        do_reset();
        btn_vol_down = 1'b1;
        tick(9);
        total++;
        if (o_vol !== 16'h2828) $display("FAIL rh_first: got %h want 2828", o_vol);
        else passed++;
        rst_n = 1'b0;
        tick(1);
        total++;
        if (o_vol !== 16'h2020) $display("FAIL rh_in_reset: got %h want 2020", o_vol);
        else passed++;
        rst_n = 1'b1;
        tick(6);
        total++;
        if (o_vol !== 16'h2020) $display("FAIL rh_no_early: got %h want 2020", o_vol);
        else passed++;
        tick(1);
        total++;
        if (o_vol !== 16'h2828) $display("FAIL rh_redebounce: got %h want 2828", o_vol);
        else passed++;
        btn_vol_down = 1'b0;
        tick(12);
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 5));
            if (r == 5) begin
                i_finish_song = 1'b1;
                tick(int'($urandom_range(1, 5)));
                i_finish_song = 1'b0;
                tick(6);
            end else begin
                press(r, int'($urandom_range(6, 12)));
            end
            model_press(r);
            total++;
            if (o_song_select !== 3'(m_song)) $display("FAIL rnd_song it%0d: got %0d want %0d", it, o_song_select, m_song);
            else passed++;
            total++;
            if (o_pause !== 1'(m_pause)) $display("FAIL rnd_pause it%0d: got %0b want %0d", it, o_pause, m_pause);
            else passed++;
            total++;
            if (o_vol !== {8'(m_att), 8'(m_att)}) $display("FAIL rnd_vol it%0d: got %h want %02h%02h", it, o_vol, m_att, m_att);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_saturation();
        test_auto_advance();
        test_simultaneous();
        test_reset_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
